edge_sched_p: RTL

EDGE_SCHED_P -- requirements
Module: edge_sched_p

---
 rtl/edge_sched_p.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/edge_sched_p.sv
// edge_sched_p: packs per-edge feature ranges into LANES-wide SIMD slots.
// Each slot holds at most two edge segments. When the current edge does
// not fill a slot, the head of the edge FIFO is popped into the free lanes.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. While valid is high and ready is low, the producer holds
// every payload signal stable.
// Optional feature: define ESCHED_STATS_EN to add the saturating
// stat_slots / stat_edges / stat_idle_lanes counters.
module edge_sched_p #(
  parameter int LANES      = 64,
  parameter int FDIM_W     = 12,
  parameter int EDGE_W     = 24,
  parameter int BANKS      = 8,
  parameter int BANK_SHIFT = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FDIM_W-1:0] cfg_fdim,
  input  logic              e_valid,
  input  logic [EDGE_W-1:0] e_data,
  input  logic              e_last,
  output logic              e_ready,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [EDGE_W-1:0] s_edge0,
  output logic [EDGE_W-1:0] s_edge1,
  output logic [FDIM_W-1:0] s_start0,
  output logic [FDIM_W-1:0] s_stop0,
  output logic [FDIM_W-1:0] s_start1,
  output logic [FDIM_W-1:0] s_stop1,
  output logic              s_two,
  output logic [LANES-1:0]  s_lane_mask,
  output logic [BANKS-1:0]  s_bank_en,
  output logic              busy,
  output logic              task_done
`ifdef ESCHED_STATS_EN
  ,
  output logic [31:0]       stat_slots,
  output logic [31:0]       stat_edges,
  output logic [31:0]       stat_idle_lanes
`endif
);

  localparam int LB = $clog2(LANES);
  localparam int CW = ((FDIM_W + 1) > (LB + 1)) ? (FDIM_W + 1) : (LB + 1);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fd_q;
  logic              cur_vld, cur_last;
  logic [EDGE_W-1:0] cur_edge;
  logic [CW-1:0]     cur_off;
  logic              out_final;

  logic [CW-1:0]     rem, n0, n1, room, tot, stop0, stop1;
  logic              build, two, load, seg0_done, final_d;
  logic [LANES-1:0]  mask_d;
  logic [BANKS-1:0]  bank_d;

  // Set of banks touched by the inclusive feature range [a, b].
  function automatic logic [BANKS-1:0] banks_of(input logic [CW-1:0] a,
                                                 input logic [CW-1:0] b);
    logic [CW-1:0]    blk_a, blk_b, blk;
    logic [BANKS-1:0] m;
    m     = '0;
    blk_a = a >> BANK_SHIFT;
    blk_b = b >> BANK_SHIFT;
    for (int k = 0; k < BANKS; k++) begin
      blk = blk_a + CW'(k);
      if (blk <= blk_b) m = m | (BANKS'(1) << (blk % CW'(BANKS)));
    end
    return m;
  endfunction

  // Slot formation from the current edge plus, optionally, the FIFO head.
  always_comb begin
    rem       = fd_q - cur_off;
    n0        = (rem < LANES_C) ? rem : LANES_C;
    seg0_done = (rem <= LANES_C);
    room      = LANES_C - rem;
    n1        = (room < fd_q) ? room : fd_q;
    build     = cur_vld && (!s_valid || s_ready);
    two       = build && (rem < LANES_C) && e_valid && !cur_last && (state_q == RUN);
    load      = (state_q == RUN) && !cur_vld && e_valid;
    e_ready   = load || two;
    tot       = n0 + (two ? n1 : '0);
    stop0     = cur_off + n0 - CW'(1);
    stop1     = n1 - CW'(1);
    final_d   = (seg0_done && cur_last) || (two && e_last && (n1 == fd_q));
    for (int i = 0; i < LANES; i++) mask_d[i] = (CW'(i) < tot);
    bank_d    = banks_of(cur_off, stop0) | (two ? banks_of('0, stop1) : '0);
  end

  // Next-state logic: the task is draining once its e_last edge is popped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (e_valid) state_d = RUN;
      RUN:     if ((load || two) && e_last) state_d = DRAIN;
      DRAIN:   if (s_valid && s_ready && out_final) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // State register and feature-count latch (cfg_fdim of 0 behaves as 1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fd_q    <= CW'(1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) fd_q <= (cfg_fdim == '0) ? CW'(1) : CW'(cfg_fdim);
    end
  end

  // Current-edge register: load, advance, or hand over to the popped head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_vld  <= 1'b0;
      cur_last <= 1'b0;
      cur_edge <= '0;
      cur_off  <= '0;
    end else if (load) begin
      cur_vld  <= 1'b1;
      cur_edge <= e_data;
      cur_off  <= '0;
      cur_last <= e_last;
    end else if (build) begin
      if (two) begin
        if (n1 == fd_q) begin
          cur_vld <= 1'b0;
        end else begin
          cur_edge <= e_data;
          cur_off  <= n1;
          cur_last <= e_last;
        end
      end else if (seg0_done) begin
        cur_vld <= 1'b0;
      end else begin
        cur_off <= cur_off + LANES_C;
      end
    end
  end

  // Output slot register: filled when empty or being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid     <= 1'b0;
      s_edge0     <= '0;
      s_edge1     <= '0;
      s_start0    <= '0;
      s_stop0     <= '0;
      s_start1    <= '0;
      s_stop1     <= '0;
      s_two       <= 1'b0;
      s_lane_mask <= '0;
      s_bank_en   <= '0;
      out_final   <= 1'b0;
      task_done   <= 1'b0;
    end else begin
      task_done <= s_valid && s_ready && out_final;
      if (build) begin
        s_valid     <= 1'b1;
        s_edge0     <= cur_edge;
        s_start0    <= cur_off[FDIM_W-1:0];
        s_stop0     <= stop0[FDIM_W-1:0];
        s_two       <= two;
        s_edge1     <= two ? e_data : '0;
        s_start1    <= '0;
        s_stop1     <= two ? stop1[FDIM_W-1:0] : '0;
        s_lane_mask <= mask_d;
        s_bank_en   <= bank_d;
        out_final   <= final_d;
      end else if (s_ready) begin
        s_valid <= 1'b0;
      end
    end
  end

`ifdef ESCHED_STATS_EN
  logic [CW-1:0] out_n;
  logic [32:0]   idle_sum;

  assign idle_sum = {1'b0, stat_idle_lanes} + 33'(LANES_C - out_n);

  // Saturating activity counters, cleared at the start of each task.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_n           <= '0;
      stat_slots      <= '0;
      stat_edges      <= '0;
      stat_idle_lanes <= '0;
    end else begin
      if (build) out_n <= tot;
      if (state_q == IDLE && state_d == RUN) begin
        stat_slots      <= '0;
        stat_edges      <= '0;
        stat_idle_lanes <= '0;
      end else begin
        if (s_valid && s_ready) begin
          if (stat_slots != '1) stat_slots <= stat_slots + 32'd1;
          stat_idle_lanes <= idle_sum[32] ? '1 : idle_sum[31:0];
        end
        if (e_ready && stat_edges != '1) stat_edges <= stat_edges + 32'd1;
      end
    end
  end
`endif

endmodule
